// File: rtl/serial_bit_tx.sv
// Parallel-to-serial transmitter: start bit (0), WIDTH data bits LSB first, stop bit (1),
// each bit held DIV cycles. All outputs are registered.
module serial_bit_tx #(
  parameter int WIDTH = 8,
  parameter int DIV   = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_ready,
  output logic             o_busy,
  output logic             o_d
);

  localparam int DW = (DIV   > 1) ? $clog2(DIV + 1)   : 1;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH + 1) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t           r_state, w_state;
  logic [DW-1:0]    r_div, w_div;
  logic [CW-1:0]    r_bitcnt, w_bitcnt;
  logic [WIDTH-1:0] r_shift, w_shift;
  logic [WIDTH-1:0] w_shift_shr;
  logic             r_d, w_d;
  logic             r_ready, w_ready;
  logic             r_busy, w_busy;
  logic             w_bit_end;

  assign w_bit_end   = (r_div == DIV_LAST);
  assign w_shift_shr = r_shift >> 1;

  // Next-state logic also computes the next registered output values, so o_d
  // already carries the level of the bit that the new state will hold.
  always_comb begin
    w_state  = r_state;
    w_div    = w_bit_end ? '0 : r_div + 1'b1;
    w_bitcnt = r_bitcnt;
    w_shift  = r_shift;
    w_d      = r_d;
    w_ready  = r_ready;
    w_busy   = r_busy;
    case (r_state)
      IDLE: begin
        w_div = '0;
        if (i_valid && r_ready) begin
          w_state = START;
          w_shift = i_data;
          w_d     = 1'b0;
          w_ready = 1'b0;
          w_busy  = 1'b1;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_state  = DATA;
          w_bitcnt = '0;
          w_d      = r_shift[0];
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_shift  = w_shift_shr;
          w_bitcnt = r_bitcnt + 1'b1;
          if (r_bitcnt == BIT_LAST) begin
            w_state = STOP;
            w_d     = 1'b1;
          end else begin
            w_d = w_shift_shr[0];
          end
        end
      end
      STOP: begin
        if (w_bit_end) begin
          w_state = IDLE;
          w_d     = 1'b1;
          w_ready = 1'b1;
          w_busy  = 1'b0;
        end
      end
      default: begin
        w_state = IDLE;
        w_div   = '0;
        w_d     = 1'b1;
        w_ready = 1'b1;
        w_busy  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_div    <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_d      <= 1'b1;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_div    <= w_div;
      r_bitcnt <= w_bitcnt;
      r_shift  <= w_shift;
      r_d      <= w_d;
      r_ready  <= w_ready;
      r_busy   <= w_busy;
    end
  end

  assign o_d     = r_d;
  assign o_ready = r_ready;
  assign o_busy  = r_busy;

endmodule

// File: tb/tb_serial_bit_tx.sv
// Scoreboard bench for serial_bit_tx: three instances (8/4, 8/1, 1/2); each accept pushes the
// expected per-cycle line levels, and every cycle pops one and compares o_d/o_ready/o_busy.
module tb_serial_bit_tx;

  localparam int NI = 3;
  localparam int WV [NI] = '{8, 8, 1};
  localparam int DV [NI] = '{4, 1, 2};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid [NI];
  logic [7:0] data  [NI];
  logic       rdy   [NI];
  logic       bsy   [NI];
  logic       sd    [NI];

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  bit          q      [NI][$];
  bit          m_idle [NI];
  int unsigned acc    [NI];
  bit          active = 1'b0;

  always #5 clk = ~clk;

  serial_bit_tx #(.WIDTH(8), .DIV(4)) u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid[0]), .i_data(data[0]),
    .o_ready(rdy[0]), .o_busy(bsy[0]), .o_d(sd[0]));

  serial_bit_tx #(.WIDTH(8), .DIV(1)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid[1]), .i_data(data[1]),
    .o_ready(rdy[1]), .o_busy(bsy[1]), .o_d(sd[1]));

  serial_bit_tx #(.WIDTH(1), .DIV(2)) u2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid[2]), .i_data(data[2][0:0]),
    .o_ready(rdy[2]), .o_busy(bsy[2]), .o_d(sd[2]));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model of the accept: the transmitter only takes a word at the end of a cycle it spent idle.
  always @(posedge clk) begin
    if (!rst_n) begin
      active = 1'b1;
      for (int k = 0; k < NI; k++) begin
        q[k].delete();
        m_idle[k] = 1'b0;
      end
    end else if (active) begin
      for (int k = 0; k < NI; k++) begin
        if (valid[k] === 1'b1 && m_idle[k]) begin
          for (int c = 0; c < DV[k]; c++) q[k].push_back(1'b0);
          for (int b = 0; b < WV[k]; b++)
            for (int c = 0; c < DV[k]; c++) q[k].push_back(data[k][b]);
          for (int c = 0; c < DV[k]; c++) q[k].push_back(1'b1);
          m_idle[k] = 1'b0;
          acc[k]++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (active) begin
      for (int k = 0; k < NI; k++) begin
        if (q[k].size() > 0) begin
          check_eq($sformatf("u%0d o_d", k), 32'(sd[k]), 32'(q[k].pop_front()));
          check_eq($sformatf("u%0d o_ready busy", k), 32'(rdy[k]), 32'd0);
          check_eq($sformatf("u%0d o_busy busy", k), 32'(bsy[k]), 32'd1);
          m_idle[k] = 1'b0;
        end else begin
          check_eq($sformatf("u%0d o_d idle", k), 32'(sd[k]), 32'd1);
          check_eq($sformatf("u%0d o_ready idle", k), 32'(rdy[k]), 32'd1);
          check_eq($sformatf("u%0d o_busy idle", k), 32'(bsy[k]), 32'd0);
          m_idle[k] = 1'b1;
        end
      end
    end
  end

  task automatic wait_acc(input int k, input int unsigned prev);
    for (int i = 0; i < 300; i++) begin
      if (acc[k] != prev) return;
      @(posedge clk);
      #2;
    end
    check_eq($sformatf("u%0d accept timeout", k), 32'd0, 32'd1);
  endtask

  task automatic send(input int k, input logic [7:0] d);
    int unsigned prev;
    @(posedge clk);
    #2;
    prev     = acc[k];
    valid[k] = 1'b1;
    data[k]  = d;
    wait_acc(k, prev);
    valid[k] = 1'b0;
    data[k]  = ~d;
  endtask

  task automatic drain();
    for (int i = 0; i < 500; i++) begin
      if (q[0].size() == 0 && q[1].size() == 0 && q[2].size() == 0) break;
      @(posedge clk);
      #2;
    end
    check_eq("drain queues empty", 32'(q[0].size() + q[1].size() + q[2].size()), 32'd0);
    repeat (3) @(posedge clk);
    #2;
  endtask

  initial begin
    int unsigned prev;
    rst_n = 1'b0;
    for (int k = 0; k < NI; k++) begin
      valid[k] = 1'b1;
      data[k]  = 8'hFF;
      acc[k]   = 0;
      m_idle[k] = 1'b0;
    end
    // Reset held for three edges with i_valid high: every instance must stay idle.
    repeat (3) @(posedge clk);
    #2;
    for (int k = 0; k < NI; k++) valid[k] = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    send(0, 8'hA5);
    send(2, 8'h01);
    drain();

    // Continuous valid: 0x00 then 0xFF, data changed right after the first accept.
    @(posedge clk);
    #2;
    prev     = acc[1];
    valid[1] = 1'b1;
    data[1]  = 8'h00;
    wait_acc(1, prev);
    data[1]  = 8'hFF;
    prev     = acc[1];
    wait_acc(1, prev);
    valid[1] = 1'b0;
    data[1]  = 8'h00;
    drain();

    // Valid pulse while busy must be ignored.
    send(0, 8'h5A);
    repeat (10) @(posedge clk);
    #2;
    valid[0] = 1'b1;
    data[0]  = 8'hFF;
    @(posedge clk);
    #2;
    valid[0] = 1'b0;
    drain();

    // Reset during data bit 3, then a clean frame.
    send(0, 8'hC3);
    repeat (17) @(posedge clk);
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    send(0, 8'h3C);
    drain();

    send(2, 8'h00);
    send(1, 8'h96);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
